// File: rtl/watch_set_ctrl.sv
// Watch time-setting control: mode sequencing, up-button increment pulses with
// auto-repeat, selected-field blink and inactivity timeout back to RUN.
// Optional build macro WATCH_SET_SEC_CLR_EN: in SET_SEC an up press clears seconds instead.
module watch_set_ctrl #(
   parameter int unsigned REPEAT_DELAY  = 50_000_000,
   parameter int unsigned REPEAT_PERIOD = 10_000_000,
   parameter int unsigned TIMEOUT_CYC   = 1_000_000_000,
   parameter int unsigned BLINK_HALF    = 25_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_mode,
   input  logic       btn_up,
   output logic       o_btn_sec,
   output logic       o_btn_min,
   output logic       o_btn_hour,
   output logic [1:0] o_mode,
   output logic       o_blink,
   output logic       o_sec_clr
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      SET_HOUR = 2'd1,
      SET_MIN  = 2'd2,
      SET_SEC  = 2'd3
   } mode_t;

   localparam int unsigned HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int HOLD_W = (HOLD_MAX > 1)    ? $clog2(HOLD_MAX)    : 1;
   localparam int TO_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam int BL_W   = (BLINK_HALF > 1)  ? $clog2(BLINK_HALF)  : 1;

   localparam logic [HOLD_W-1:0] DELAY_LAST  = HOLD_W'(REPEAT_DELAY - 1);
   localparam logic [HOLD_W-1:0] PERIOD_LAST = HOLD_W'(REPEAT_PERIOD - 1);
   localparam logic [TO_W-1:0]   TO_LAST     = TO_W'(TIMEOUT_CYC - 1);
   localparam logic [BL_W-1:0]   BL_LAST     = BL_W'(BLINK_HALF - 1);

   mode_t             state_q, state_d;
   logic              mode_prev_q, up_prev_q;
   logic              mode_rise, up_rise;
   logic              armed_q, armed_d;
   logic              rep_phase_q, rep_phase_d;
   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
   logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
   logic [BL_W-1:0]   bl_cnt_q, bl_cnt_d;
   logic              blink_q, blink_d;
   logic              hour_q, hour_d;
   logic              min_q, min_d;
   logic              sec_q, sec_d;
   logic              fire;
   logic              mode_chg;
   logic              timeout_hit;
   logic              repeat_ok;

   assign mode_rise = btn_mode & ~mode_prev_q;
   assign up_rise   = btn_up & ~up_prev_q;

   // A held up button keeps the unit alive, so it also blocks the timeout.
   assign timeout_hit = (state_q != RUN) && !mode_rise && !btn_up && (to_cnt_q == TO_LAST);

`ifdef WATCH_SET_SEC_CLR_EN
   logic sec_clr_q, sec_clr_d;
   assign repeat_ok = (state_q != SET_SEC);
`else
   assign repeat_ok = 1'b1;
`endif

   always_comb begin
      state_d     = state_q;
      armed_d     = armed_q;
      rep_phase_d = rep_phase_q;
      hold_cnt_d  = hold_cnt_q;
      to_cnt_d    = to_cnt_q;
      bl_cnt_d    = bl_cnt_q;
      blink_d     = blink_q;
      fire        = 1'b0;
      mode_chg    = 1'b0;

      if (state_q == RUN) begin
         armed_d     = 1'b0;
         rep_phase_d = 1'b0;
         hold_cnt_d  = '0;
         to_cnt_d    = '0;
         bl_cnt_d    = '0;
         blink_d     = 1'b0;
         if (mode_rise) begin
            state_d = SET_HOUR;
         end
      end else begin
         mode_chg = mode_rise | timeout_hit;

         if (mode_rise) begin
            case (state_q)
               SET_HOUR: state_d = SET_MIN;
               SET_MIN:  state_d = SET_SEC;
               default:  state_d = RUN;
            endcase
         end else if (timeout_hit) begin
            state_d = RUN;
         end

         if (mode_rise || btn_up || timeout_hit) begin
            to_cnt_d = '0;
         end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
         end

         if (mode_chg) begin
            bl_cnt_d = '0;
            blink_d  = 1'b0;
         end else if (bl_cnt_q == BL_LAST) begin
            bl_cnt_d = '0;
            blink_d  = ~blink_q;
         end else begin
            bl_cnt_d = bl_cnt_q + BL_W'(1);
         end

         // Repeat is armed only by a press that produced a pulse; a mode change disarms it.
         if (mode_chg || !btn_up) begin
            armed_d     = 1'b0;
            rep_phase_d = 1'b0;
            hold_cnt_d  = '0;
         end else if (up_rise) begin
            fire        = 1'b1;
            armed_d     = repeat_ok;
            rep_phase_d = 1'b0;
            hold_cnt_d  = '0;
         end else if (armed_q) begin
            if (!rep_phase_q) begin
               if (hold_cnt_q == DELAY_LAST) begin
                  fire        = 1'b1;
                  rep_phase_d = 1'b1;
                  hold_cnt_d  = '0;
               end else begin
                  hold_cnt_d = hold_cnt_q + HOLD_W'(1);
               end
            end else begin
               if (hold_cnt_q == PERIOD_LAST) begin
                  fire       = 1'b1;
                  hold_cnt_d = '0;
               end else begin
                  hold_cnt_d = hold_cnt_q + HOLD_W'(1);
               end
            end
         end else begin
            hold_cnt_d = '0;
         end
      end

      hour_d = fire && (state_q == SET_HOUR);
      min_d  = fire && (state_q == SET_MIN);
`ifdef WATCH_SET_SEC_CLR_EN
      sec_d     = 1'b0;
      sec_clr_d = fire && (state_q == SET_SEC);
`else
      sec_d = fire && (state_q == SET_SEC);
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= RUN;
         mode_prev_q <= 1'b1;
         up_prev_q   <= 1'b1;
         armed_q     <= 1'b0;
         rep_phase_q <= 1'b0;
         hold_cnt_q  <= '0;
         to_cnt_q    <= '0;
         bl_cnt_q    <= '0;
         blink_q     <= 1'b0;
         hour_q      <= 1'b0;
         min_q       <= 1'b0;
         sec_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         mode_prev_q <= btn_mode;
         up_prev_q   <= btn_up;
         armed_q     <= armed_d;
         rep_phase_q <= rep_phase_d;
         hold_cnt_q  <= hold_cnt_d;
         to_cnt_q    <= to_cnt_d;
         bl_cnt_q    <= bl_cnt_d;
         blink_q     <= blink_d;
         hour_q      <= hour_d;
         min_q       <= min_d;
         sec_q       <= sec_d;
      end
   end

`ifdef WATCH_SET_SEC_CLR_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         sec_clr_q <= 1'b0;
      end else begin
         sec_clr_q <= sec_clr_d;
      end
   end
   assign o_sec_clr = sec_clr_q;
`else
   assign o_sec_clr = 1'b0;
`endif

   assign o_mode     = state_q;
   assign o_blink    = blink_q;
   assign o_btn_hour = hour_q;
   assign o_btn_min  = min_q;
   assign o_btn_sec  = sec_q;

endmodule

// File: tb/tb_watch_set_ctrl.sv
// Bench for watch_set_ctrl with short timing parameters; pulse and mode events
// are predicted by the stimulus and matched by an independent monitor.
module tb_watch_set_ctrl;

   localparam int W = 36;

   logic       clk;
   logic       reset;
   logic       btn_mode;
   logic       btn_up;
   logic       o_btn_sec;
   logic       o_btn_min;
   logic       o_btn_hour;
   logic [1:0] o_mode;
   logic       o_blink;
   logic       o_sec_clr;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] mode_q[$];

   int cyc     = 0;
   int n_check = 0;
   int n_fail  = 0;

   localparam logic [3:0] P_SEC  = 4'b0001;
   localparam logic [3:0] P_MIN  = 4'b0010;
   localparam logic [3:0] P_HOUR = 4'b0100;
   localparam logic [3:0] P_CLR  = 4'b1000;

   watch_set_ctrl #(
      .REPEAT_DELAY (8),
      .REPEAT_PERIOD(3),
      .TIMEOUT_CYC  (20),
      .BLINK_HALF   (4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .btn_mode  (btn_mode),
      .btn_up    (btn_up),
      .o_btn_sec (o_btn_sec),
      .o_btn_min (o_btn_min),
      .o_btn_hour(o_btn_hour),
      .o_mode    (o_mode),
      .o_blink   (o_blink),
      .o_sec_clr (o_sec_clr)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_check++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [W-1:0] ev(input int c, input logic [3:0] v);
      logic [31:0] cc;
      cc = c;
      return {cc, v};
   endfunction

   // monitor: samples 1 time unit after each active edge; cyc = edges seen
   logic [1:0] mode_seen = 2'd0;
   always @(posedge clk) begin
      logic [3:0] pv;
      logic [W-1:0] e;
      #1;
      cyc = cyc + 1;
      pv = {o_sec_clr, o_btn_hour, o_btn_min, o_btn_sec};
      if (pv !== 4'b0000) begin
         check("pulse_onehot", W'($countones(pv) == 1), W'(1));
         if (exp_q.size() == 0) begin
            check("pulse_unexpected", ev(cyc, pv), ev(cyc, 4'b0000));
         end else begin
            e = exp_q.pop_front();
            check("pulse", ev(cyc, pv), e);
         end
      end
      if (o_mode !== mode_seen) begin
         if (mode_q.size() == 0) begin
            check("mode_unexpected", ev(cyc, {2'b00, o_mode}), ev(cyc, {2'b00, mode_seen}));
         end else begin
            e = mode_q.pop_front();
            check("mode", ev(cyc, {2'b00, o_mode}), e);
         end
         mode_seen = o_mode;
      end
   end

   // driver tasks (all called at a negedge)
   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press_mode(input logic [1:0] next_mode);
      btn_mode = 1'b1;
      mode_q.push_back(ev(cyc + 1, {2'b00, next_mode}));
      @(negedge clk);
      btn_mode = 1'b0;
   endtask

   // up held for n sampled edges; returns with btn_up low
   task automatic hold_up(input int n);
      btn_up = 1'b1;
      idle(n);
      btn_up = 1'b0;
   endtask

   initial begin
      int e;
      reset    = 1'b1;
      btn_mode = 1'b0;
      btn_up   = 1'b0;
      idle(3);
      check("rst_mode",    W'(o_mode), W'(0));
      check("rst_blink",   W'(o_blink), W'(0));
      check("rst_pulses",  W'({o_btn_hour, o_btn_min, o_btn_sec}), W'(0));
      check("rst_sec_clr", W'(o_sec_clr), W'(0));
      reset = 1'b0;
      idle(2);

      // mode cycling with blink profile: 0 for 4 cycles, then 1 in SET states
      for (int p = 0; p < 4; p++) begin
         logic [1:0] m;
         m = 2'((p + 1) % 4);
         press_mode(m);
         for (int k = 0; k < 5; k++) begin
            check("blink", W'(o_blink), W'((m != 2'd0) && (k >= 4)));
            if (k < 4) idle(1);
         end
      end
      idle(2);

      // single press in SET_MIN
      press_mode(2'd1); idle(1);
      press_mode(2'd2); idle(2);
      exp_q.push_back(ev(cyc + 1, P_MIN));
      hold_up(1);
      idle(4);

      // long hold in SET_HOUR: E, E+8, E+11, E+14, E+17
      press_mode(2'd3); idle(1);
      press_mode(2'd0); idle(1);
      press_mode(2'd1); idle(2);
      e = cyc + 1;
      exp_q.push_back(ev(e, P_HOUR));
      exp_q.push_back(ev(e + 8, P_HOUR));
      exp_q.push_back(ev(e + 11, P_HOUR));
      exp_q.push_back(ev(e + 14, P_HOUR));
      exp_q.push_back(ev(e + 17, P_HOUR));
      hold_up(20);
      idle(3);
      check("hold_drained", W'(exp_q.size()), W'(0));

      // inactivity in SET_SEC returns to RUN after 20 idle cycles
      press_mode(2'd2); idle(1);
      press_mode(2'd3);
      mode_q.push_back(ev(cyc + 20, 4'd0));
      idle(22);
      check("timeout_mode", W'(o_mode), W'(0));
      hold_up(1);
      idle(3);

      // mode and up rise together: mode wins, no repeat from that hold
      press_mode(2'd1); idle(2);
      btn_mode = 1'b1;
      btn_up   = 1'b1;
      mode_q.push_back(ev(cyc + 1, 4'd2));
      idle(1);
      btn_mode = 1'b0;
      idle(12);
      btn_up = 1'b0;
      idle(2);
      check("simul_mode", W'(o_mode), W'(2));
      exp_q.push_back(ev(cyc + 1, P_MIN));
      hold_up(1);
      idle(2);

      // reset while up held in SET_MIN
      btn_up = 1'b1;
      exp_q.push_back(ev(cyc + 1, P_MIN));
      idle(3);
      reset = 1'b1;
      mode_q.push_back(ev(cyc + 1, 4'd0));
      idle(1);
      check("rstmid_mode",   W'(o_mode), W'(0));
      check("rstmid_pulses", W'({o_sec_clr, o_btn_hour, o_btn_min, o_btn_sec}), W'(0));
      check("rstmid_blink",  W'(o_blink), W'(0));
      idle(1);
      reset = 1'b0;
      idle(3);
      press_mode(2'd1);
      idle(12);
      btn_up = 1'b0;
      idle(2);

      // SET_SEC press held 12 cycles
      press_mode(2'd2); idle(1);
      press_mode(2'd3); idle(1);
      e = cyc + 1;
`ifdef WATCH_SET_SEC_CLR_EN
      exp_q.push_back(ev(e, P_CLR));
`else
      exp_q.push_back(ev(e, P_SEC));
      exp_q.push_back(ev(e + 8, P_SEC));
      exp_q.push_back(ev(e + 11, P_SEC));
`endif
      hold_up(12);
      idle(4);

      check("pulse_q_empty", W'(exp_q.size()), W'(0));
      check("mode_q_empty",  W'(mode_q.size()), W'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
      $finish;
   end

endmodule
